// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_unit                                                      |
// | Purpose  : Instruction fetch front end. Generates sequential PCs, issues   |
// |            requests to instruction memory and keeps the returned words in  |
// |            a small in-order queue for decode. A redirect retargets fetch,  |
// |            flushes the queue and discards stale in-flight responses.       |
// | Ports    : clk_i, reset_i (async, active-high)                             |
// |            imem_req_o/imem_addr_o/imem_gnt_i   - request channel           |
// |            imem_rvalid_i/imem_rdata_i          - in-order response channel |
// |            redirect_i/redirect_pc_i            - fetch retarget            |
// |            pc_o/inst_valid_o/inst_o/inst_ready_i - decode handshake        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        inst_ready_i,
  output logic [31:0] pc_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;  // index bits plus a wrap bit
  localparam logic [PW-1:0] C_DEPTH = PW'(DEPTH);
  localparam logic [PW-1:0] C_ONE   = PW'(1);

  // Queue pointers, stale-response counter and fetch PC
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]   fpc_q, fpc_d;

  // Queue storage
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  logic [PW-1:0] count_w;
  logic [PW-1:0] outs_w;
  logic [AW-1:0] head_idx_w;
  logic          req_w;
  logic          gnt_w;
  logic          rsp_w;
  logic          drop_w;
  logic          wr_w;
  logic          valid_w;
  logic          pop_w;

  // Drop counter plus allocated-but-unfilled entries never exceeds DEPTH,
  // so both sums fit in the pointer width.
  assign count_w    = tail_q - head_q;
  assign outs_w     = drop_cnt_q + (tail_q - fill_q);
  assign head_idx_w = head_q[AW-1:0];

  // Reset gates the request combinationally so it is low while reset is held.
  assign req_w   = !reset_i && !redirect_i && (count_w < C_DEPTH) && (outs_w < C_DEPTH);
  assign gnt_w   = req_w && imem_gnt_i;
  // A response with nothing outstanding is a protocol violation and ignored.
  assign rsp_w   = imem_rvalid_i && (outs_w != '0) && !redirect_i;
  assign drop_w  = rsp_w && (drop_cnt_q != '0);
  assign wr_w    = rsp_w && (drop_cnt_q == '0);
  assign valid_w = (count_w != '0) && filled_q[head_idx_w];
  assign pop_w   = valid_w && inst_ready_i && !redirect_i;

  always_comb begin
    tail_d     = tail_q;
    fill_d     = fill_q;
    head_d     = head_q;
    drop_cnt_d = drop_cnt_q;
    fpc_d      = fpc_q;
    if (redirect_i) begin
      tail_d = '0;
      fill_d = '0;
      head_d = '0;
      fpc_d  = redirect_pc_i;
      // Everything outstanding becomes stale; a response landing this very
      // cycle is already consumed, so it is not counted again.
      if (outs_w == '0) begin
        drop_cnt_d = '0;
      end else begin
        drop_cnt_d = outs_w - PW'(imem_rvalid_i);
      end
    end else begin
      if (gnt_w) begin
        tail_d = tail_q + C_ONE;
        fpc_d  = fpc_q + 32'd4;
      end
      if (drop_w) begin
        drop_cnt_d = drop_cnt_q - C_ONE;
      end
      if (wr_w) begin
        fill_d = fill_q + C_ONE;
      end
      if (pop_w) begin
        head_d = head_q + C_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tail_q     <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      drop_cnt_q <= '0;
      fpc_q      <= RESET_PC;
    end else begin
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      drop_cnt_q <= drop_cnt_d;
      fpc_q      <= fpc_d;
    end
  end

  // Allocation and fill never target the same slot in one cycle: that would
  // require DEPTH requests in flight, which already blocks the request.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]     <= '0;
        inst_q[i]   <= '0;
        filled_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (gnt_w && (tail_q[AW-1:0] == AW'(i))) begin
          pc_q[i]     <= fpc_q;
          filled_q[i] <= 1'b0;
        end
        if (wr_w && (fill_q[AW-1:0] == AW'(i))) begin
          inst_q[i]   <= imem_rdata_i;
          filled_q[i] <= 1'b1;
        end
      end
    end
  end

  assign imem_req_o   = req_w;
  assign imem_addr_o  = fpc_q;
  assign inst_valid_o = valid_w;
  assign pc_o         = pc_q[head_idx_w];
  assign inst_o       = inst_q[head_idx_w];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                                   |
// | Purpose  : Self-checking bench for fetch_unit. An in-order memory          |
// |            responder with random latency feeds the DUT while a queue-based |
// |            reference model predicts every visible output.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        inst_ready_i = 1'b0;
  logic [31:0] pc_o;
  logic        inst_valid_o;
  logic [31:0] inst_o;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .inst_ready_i (inst_ready_i),
    .pc_o         (pc_o),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: fetched entries in program order, stale count, fetch PC
  typedef struct {logic [31:0] pc; bit filled;} ent_t;
  ent_t        mq[$];
  int          drop;
  logic [31:0] mfpc;

  // Memory responder: granted addresses with the cycle they may return
  typedef struct {logic [31:0] addr; int due;} req_t;
  req_t pend[$];
  int   cyc;

  int checks = 0;
  int errors = 0;
  int gnt_pct, rdy_pct, lat_lo, lat_hi;
  int ngnt, npop;
  bit          seen;
  logic [31:0] first_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int unfilled();
    int n = 0;
    foreach (mq[i]) if (!mq[i].filled) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check, advance model at posedge.
  task automatic cycle(input bit rd, input logic [31:0] rpc);
    int          outs_m, lat, c;
    bit          ereq, evalid, g, rv, found;
    logic [31:0] gaddr;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    imem_gnt_i    = ($urandom_range(99, 0) < gnt_pct);
    inst_ready_i  = ($urandom_range(99, 0) < rdy_pct);
    rv            = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? memf(pend[0].addr) : $urandom;
    #1;
    outs_m = drop + unfilled();
    ereq   = !rd && (mq.size() < DEPTH) && (outs_m < DEPTH);
    evalid = (mq.size() > 0) && mq[0].filled;
    chk("req", 32'(imem_req_o), 32'(ereq));
    chk("addr", imem_addr_o, mfpc);
    chk("valid", 32'(inst_valid_o), 32'(evalid));
    if (evalid) begin
      chk("pc", pc_o, mq[0].pc);
      chk("inst", inst_o, memf(mq[0].pc));
    end
    if (rv) begin
      assert (outs_m > 0) else begin
        errors++;
        $error("FAIL protocol rvalid with %0d outstanding", outs_m);
      end
    end
    if (inst_valid_o && !seen) begin
      seen     = 1'b1;
      first_pc = pc_o;
    end
    g     = imem_req_o && imem_gnt_i;
    gaddr = imem_addr_o;
    if (g) ngnt++;
    if (inst_valid_o && inst_ready_i) npop++;
    c = cyc;
    @(posedge clk_i);
    cyc++;
    if (rv) pend.delete(0);
    if (g) begin
      lat = $urandom_range(lat_hi, lat_lo);
      pend.push_back('{addr: gaddr, due: c + lat});
    end
    if (rd) begin
      mq.delete();
      drop = (outs_m > 0) ? outs_m - int'(rv) : 0;
      mfpc = rpc;
    end else begin
      if (rv && outs_m > 0) begin
        if (drop > 0) begin
          drop--;
        end else begin
          found = 1'b0;
          for (int i = 0; i < mq.size(); i++) begin
            if (!found && !mq[i].filled) begin
              mq[i].filled = 1'b1;
              found = 1'b1;
            end
          end
        end
      end
      if (evalid && inst_ready_i) mq.delete(0);
      if (ereq && imem_gnt_i) begin
        mq.push_back('{pc: mfpc, filled: 1'b0});
        mfpc = mfpc + 32'd4;
      end
    end
    @(negedge clk_i);
    redirect_i = 1'b0;
  endtask

  // Called at a negedge; mid=1 asserts reset between clock edges.
  task automatic do_reset(input bit mid);
    if (mid) #2;
    reset_i       = 1'b1;
    redirect_i    = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    inst_ready_i  = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_addr", imem_addr_o, RST_PC);
    pend.delete();
    mq.delete();
    drop = 0;
    mfpc = RST_PC;
    ngnt = 0;
    npop = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    cyc = 0;
  endtask

  task automatic knobs(input int g, input int r, input int lo, input int hi);
    gnt_pct = g;
    rdy_pct = r;
    lat_lo  = lo;
    lat_hi  = hi;
  endtask

  initial begin
    @(negedge clk_i);

    // Streaming: one instruction per cycle after two cycles of startup
    do_reset(1'b0);
    knobs(100, 100, 1, 1);
    repeat (20) cycle(1'b0, '0);
    chk("stream_pops", 32'(npop), 32'd18);

    // Back-pressure: queue fills with four grants, then drains in order
    do_reset(1'b0);
    knobs(100, 0, 1, 1);
    repeat (10) cycle(1'b0, '0);
    chk("bp_grants", 32'(ngnt), 32'd4);
    chk("bp_req", 32'(imem_req_o), 32'd0);
    chk("bp_pc", pc_o, 32'h0000_1000);
    knobs(100, 100, 1, 1);
    repeat (10) cycle(1'b0, '0);

    // Redirect with two stale responses in flight
    do_reset(1'b0);
    knobs(100, 100, 3, 3);
    repeat (2) cycle(1'b0, '0);
    cycle(1'b1, 32'h0000_2000);
    seen = 1'b0;
    repeat (12) cycle(1'b0, '0);
    chk("redir_first_pc", first_pc, 32'h0000_2000);

    // Redirect coinciding with a response, three outstanding
    do_reset(1'b0);
    knobs(100, 100, 3, 3);
    repeat (3) cycle(1'b0, '0);
    cycle(1'b1, 32'h0000_3000);
    chk("redir_drop", 32'(dut.drop_cnt_q), 32'd2);
    seen = 1'b0;
    repeat (12) cycle(1'b0, '0);
    chk("redir_rsp_first_pc", first_pc, 32'h0000_3000);

    // Grant stall: address holds, no duplicates once grants return
    do_reset(1'b0);
    knobs(100, 100, 1, 1);
    repeat (4) cycle(1'b0, '0);
    knobs(0, 100, 1, 1);
    repeat (5) cycle(1'b0, '0);
    chk("stall_addr", imem_addr_o, 32'h0000_1010);
    chk("stall_grants", 32'(ngnt), 32'd4);
    knobs(100, 100, 1, 1);
    repeat (8) cycle(1'b0, '0);

    // Reset mid-stream with three entries queued
    do_reset(1'b0);
    knobs(100, 0, 1, 1);
    repeat (3) cycle(1'b0, '0);
    knobs(0, 0, 1, 1);
    repeat (2) cycle(1'b0, '0);
    chk("pre_rst_valid", 32'(inst_valid_o), 32'd1);
    do_reset(1'b1);
    knobs(100, 100, 1, 1);
    repeat (6) cycle(1'b0, '0);

    // Randomized traffic with occasional redirects
    do_reset(1'b0);
    knobs(70, 60, 1, 4);
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(99, 0) < 4)
        cycle(1'b1, $urandom & 32'hFFFF_FFFC);
      else
        cycle(1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the out-of-order core. It generates sequential PCs, issues requests to instruction memory and buffers returned instructions in a small in-order queue. It presents them to the decode stage as `pc_o` / `inst_valid_o` / `inst_o` with a ready handshake. A redirect from branch resolution retargets fetch, flushes the queue and discards stale in-flight memory responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 4: queue entries, which is also the maximum number of outstanding memory requests. Must be a power of 2 and at least 2.

Ports:
- `clk_i` in 1: the single clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out 32: fetch address, equal to the fetch PC register `fpc`.
- `imem_gnt_i` in 1: request accepted when `imem_req_o & imem_gnt_i`.
- `imem_rvalid_i` in 1: response valid. Responses return in request order, latency ≥1 cycle.
- `imem_rdata_i` in 32: instruction word.
- `redirect_i` in 1: branch or exception redirect.
- `redirect_pc_i` in 32: new fetch PC.
- `inst_ready_i` in 1: decode accepts the head instruction.
- `pc_o` out 32: PC of the head instruction.
- `inst_valid_o` out 1: head instruction is valid.
- `inst_o` out 32: head instruction word.

## Operation
- **Queue structure.** Circular queue with three pointers, each log2(DEPTH)+1 bits with a wrap bit:
  - `tail`: allocation pointer.
  - `fill`: next entry awaiting a response.
  - `head`: output pointer.
  - Occupancy is `count = tail - head`. Each entry holds `pc`, `inst` and a `filled` flag.
- **Drop counter.** `drop_cnt` (0..DEPTH) counts stale responses still to be discarded. Total outstanding requests are `outs = drop_cnt + (tail - fill)`.
- **Request.** `imem_req_o = !redirect_i && count < DEPTH && outs < DEPTH`.
  - `imem_req_o` may deassert without a grant; there is no stability requirement.
  - On a grant: `entry[tail].pc = fpc`, `filled = 0`, `tail++`, `fpc += 4` (mod 2^32).
- **Response.**
  - If `imem_rvalid_i` and `drop_cnt > 0`: `drop_cnt--` and the data is discarded.
  - Otherwise: `entry[fill].inst = imem_rdata_i`, `filled = 1`, `fill++`.
- **Output.**
  - `inst_valid_o = (count > 0) && entry[head].filled`.
  - `pc_o` and `inst_o` are driven from `entry[head]` as register outputs.
  - A pop happens when `inst_valid_o & inst_ready_i`, and advances `head++`.
- **Redirect** takes priority over everything else:
  - `head = fill = tail = 0`, `fpc = redirect_pc_i`.
  - `drop_cnt = outs - imem_rvalid_i`, so a response arriving in the redirect cycle is discarded.
  - No grant or pop takes effect in that cycle.
- **Simultaneous events.** Grant, response and pop may all occur in the same cycle, and each updates its own pointer. `count` and `outs` for the request condition are taken from the current-cycle register values, not post-pop values.
- **Protocol violation.** `imem_rvalid_i` with `outs == 0` is ignored, and the bench flags it with an assertion.
- **Reset** (asynchronous, takes effect immediately, also mid-operation):
  - All pointers and `drop_cnt` = 0, all `filled` = 0, `fpc = RESET_PC`.
  - Outputs: `inst_valid_o = 0`, `imem_req_o = 0`, `pc_o = 0`, `inst_o = 0`.
  - `imem_addr_o = RESET_PC`.

## Timing
- Request at cycle N is granted at N. A response at N+L drives `inst_valid_o` at N+L+1. Total fetch-to-decode latency is L+1.
- With L=1, `imem_gnt_i=1`, `inst_ready_i=1` and DEPTH ≥ 2, sustained throughput is one instruction per cycle after startup.
- First `imem_req_o` is in the first cycle after `reset_i` deasserts.
- **Redirect at cycle R:**
  - `imem_req_o = 0` at R.
  - `inst_valid_o = 0` at R+1.
  - `imem_req_o` may assert at R+1 with `imem_addr_o = redirect_pc_i`, subject to `outs < DEPTH`.
- **Full queue** (`count == DEPTH`): no requests until a pop. The pop frees the slot for a request in the following cycle.
- **Back-pressure:** `inst_ready_i=0` holds `pc_o`, `inst_o` and `inst_valid_o` stable.

## Test plan
- **Streaming:** RESET_PC=0x1000, L=1, gnt=1, ready=1. Expect addresses 0x1000, 0x1004, 0x1008… on consecutive cycles. `inst_valid_o` rises 2 cycles after the first request, one instruction per cycle, `pc_o` in order and `inst_o` matching memory contents.
- **Back-pressure:** ready=0 from reset, L=1. Expect exactly 4 grants, then `imem_req_o = 0` with `inst_valid_o` held on 0x1000. Setting ready=1 drains 0x1000–0x100C in order and requests resume at 0x1010.
- **Redirect with stale responses:** L=3, redirect to 0x2000 with 2 requests in flight. The 2 stale responses are dropped, and the next `inst_valid_o` carries `pc_o = 0x2000` with the 0x2000 data.
- **Redirect on a response cycle:** redirect coincides with `imem_rvalid_i` while 3 requests are outstanding. Expect `drop_cnt = 2`, that data never appears, and the first output is `redirect_pc_i`.
- **Grant stall:** gnt=0 for 5 cycles. `imem_addr_o` stays at the same value, `tail` does not move, and no duplicates appear after gnt returns to 1.
- **Reset mid-stream:** assert `reset_i` with 3 entries queued. `inst_valid_o`, `imem_req_o`, `pc_o` and `inst_o` drop to 0 in the same cycle, and after release fetch restarts at RESET_PC.
